// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
//  rtc_pkg
//  Mode and cursor codes shared by the cursor sequencer, the character
//  generator and the RTC write logic.
//  Rev 1.0
// ============================================================================
package rtc_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_HORA   = 2'd1,
        MODE_FECHA  = 2'd2,
        MODE_TIMER  = 2'd3
    } mode_t;

    localparam logic [1:0] CUR_DER = 2'd0;
    localparam logic [1:0] CUR_MED = 2'd1;
    localparam logic [1:0] CUR_IZQ = 2'd2;

    function automatic mode_t next_mode(input mode_t m);
        return mode_t'(m + 2'd1);
    endfunction

    function automatic logic [1:0] cursor_left(input logic [1:0] c);
        return (c == CUR_IZQ) ? CUR_DER : c + 2'd1;
    endfunction

    function automatic logic [1:0] cursor_right(input logic [1:0] c);
        return (c == CUR_DER) ? CUR_IZQ : c - 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_cursor_config_if.sv
`default_nettype none
// ============================================================================
//  control_cursor_config_if
//  Button levels in, configuration/cursor state and inc/dec pulses out.
//  Rev 1.0
// ============================================================================
interface control_cursor_config_if;

    logic       btn_modo;
    logic       btn_izq;
    logic       btn_der;
    logic       btn_arriba;
    logic       btn_abajo;
    logic [1:0] config_mode;
    logic [1:0] cursor_location;
    logic       parpadeo;
    logic       inc;
    logic       dec;

    modport master (
        output btn_modo, btn_izq, btn_der, btn_arriba, btn_abajo,
        input  config_mode, cursor_location, parpadeo, inc, dec
    );

    modport slave (
        input  btn_modo, btn_izq, btn_der, btn_arriba, btn_abajo,
        output config_mode, cursor_location, parpadeo, inc, dec
    );

endinterface
`default_nettype wire

// File: rtl/detector_flanco.sv
`default_nettype none
// ============================================================================
//  detector_flanco
//  Registered rising-edge detector; history resets high so a level held
//  through reset never produces a pulse.
//  Rev 1.0
// ============================================================================
module detector_flanco (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic level,
    output logic      pulse
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= 1'b1;
            pulse  <= 1'b0;
        end else begin
            r_prev <= level;
            pulse  <= level & ~r_prev;
        end
    end

endmodule
`default_nettype wire

// File: rtl/control_cursor_config.sv
`default_nettype none
// ============================================================================
//  control_cursor_config
//  Button-driven configuration sequencer: mode FSM, cursor, blink flag,
//  inc/dec pulses and inactivity timeout back to normal display.
//  Rev 1.0
// ============================================================================
module control_cursor_config
    import rtc_pkg::*;
#(
    parameter int BLINK_HALF  = 25_000_000,
    parameter int TIMEOUT_CYC = 500_000_000,
    parameter int CNT_W       = 29
) (
    input  wire logic              clk,
    input  wire logic              reset,
    control_cursor_config_if.slave bus
);

    localparam int EV_ABAJO  = 0;
    localparam int EV_ARRIBA = 1;
    localparam int EV_DER    = 2;
    localparam int EV_IZQ    = 3;
    localparam int EV_MODO   = 4;
    localparam int N_BTN     = 5;

    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(TIMEOUT_CYC - 1);

    logic [N_BTN-1:0] w_level;
    logic [N_BTN-1:0] w_ev;
    logic             w_ev_modo;
    logic             w_ev_izq;
    logic             w_ev_der;
    logic             w_ev_arriba;
    logic             w_ev_abajo;
    logic             w_any_ev;

    mode_t            r_state;
    logic [1:0]       r_cursor;
    logic             r_parpadeo;
    logic             r_inc;
    logic             r_dec;
    logic [CNT_W-1:0] r_blink_cnt;
    logic [CNT_W-1:0] r_idle_cnt;

    assign w_level[EV_ABAJO]  = bus.btn_abajo;
    assign w_level[EV_ARRIBA] = bus.btn_arriba;
    assign w_level[EV_DER]    = bus.btn_der;
    assign w_level[EV_IZQ]    = bus.btn_izq;
    assign w_level[EV_MODO]   = bus.btn_modo;

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_edge
            detector_flanco u_det (
                .clk   (clk),
                .reset (reset),
                .level (w_level[gi]),
                .pulse (w_ev[gi])
            );
        end
    endgenerate

    assign w_ev_modo   = w_ev[EV_MODO];
    assign w_ev_izq    = w_ev[EV_IZQ];
    assign w_ev_der    = w_ev[EV_DER];
    assign w_ev_arriba = w_ev[EV_ARRIBA];
    assign w_ev_abajo  = w_ev[EV_ABAJO];
    assign w_any_ev    = w_ev_izq | w_ev_der | w_ev_arriba | w_ev_abajo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= MODE_NORMAL;
            r_cursor    <= CUR_DER;
            r_parpadeo  <= 1'b0;
            r_inc       <= 1'b0;
            r_dec       <= 1'b0;
            r_blink_cnt <= '0;
            r_idle_cnt  <= '0;
        end else begin
            r_inc <= 1'b0;
            r_dec <= 1'b0;
            // modo wins the cycle: every other event seen alongside it is dropped
            if (w_ev_modo) begin
                r_state     <= next_mode(r_state);
                r_blink_cnt <= '0;
                r_idle_cnt  <= '0;
                if (next_mode(r_state) == MODE_NORMAL) begin
                    r_cursor   <= CUR_DER;
                    r_parpadeo <= 1'b0;
                end else begin
                    r_cursor   <= CUR_IZQ;
                    r_parpadeo <= 1'b1;
                end
            end else if (r_state == MODE_NORMAL) begin
                r_parpadeo  <= 1'b0;
                r_blink_cnt <= '0;
                r_idle_cnt  <= '0;
            end else if (w_any_ev) begin
                if (w_ev_izq && !w_ev_der) begin
                    r_cursor <= cursor_left(r_cursor);
                end else if (w_ev_der && !w_ev_izq) begin
                    r_cursor <= cursor_right(r_cursor);
                end
                r_inc       <= w_ev_arriba & ~w_ev_abajo;
                r_dec       <= w_ev_abajo & ~w_ev_arriba;
                r_parpadeo  <= 1'b1;
                r_blink_cnt <= '0;
                r_idle_cnt  <= '0;
            end else if (r_idle_cnt == IDLE_LAST) begin
                r_state     <= MODE_NORMAL;
                r_cursor    <= CUR_DER;
                r_parpadeo  <= 1'b0;
                r_blink_cnt <= '0;
                r_idle_cnt  <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
                if (r_blink_cnt == BLINK_LAST) begin
                    r_blink_cnt <= '0;
                    r_parpadeo  <= ~r_parpadeo;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.config_mode     = r_state;
    assign bus.cursor_location = r_cursor;
    assign bus.parpadeo        = r_parpadeo;
    assign bus.inc             = r_inc;
    assign bus.dec             = r_dec;

endmodule
`default_nettype wire

// File: tb/tb_control_cursor_config.sv
`default_nettype none
// ============================================================================
//  tb_control_cursor_config
//  Scoreboard bench: stimulus pushes model predictions, a monitor compares.
//  Rev 1.0
// ============================================================================
module tb_control_cursor_config;

    localparam int BLINK = 4;
    localparam int TMO   = 20;

    // button vector bit order: {modo, izq, der, arriba, abajo}
    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_MODO = 5'b10000;
    localparam logic [4:0] B_IZQ  = 5'b01000;
    localparam logic [4:0] B_DER  = 5'b00100;
    localparam logic [4:0] B_ARR  = 5'b00010;
    localparam logic [4:0] B_ABA  = 5'b00001;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    control_cursor_config_if bus ();

    control_cursor_config #(
        .BLINK_HALF  (BLINK),
        .TIMEOUT_CYC (TMO),
        .CNT_W       (29)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         m_mode;
    int         m_cur;
    int         m_age;
    bit         m_inc;
    bit         m_dec;
    logic [4:0] m_prev;
    logic [4:0] m_pend;
    logic [6:0] exp_q[$];
    int         vectors    = 0;
    int         miscompares = 0;

    task automatic model_apply(input logic [4:0] ev);
        m_inc = 1'b0;
        m_dec = 1'b0;
        if (ev[4]) begin
            m_mode = (m_mode + 1) % 4;
            m_age  = 0;
            m_cur  = (m_mode == 0) ? 0 : 2;
        end else if (m_mode != 0) begin
            if (ev[3] && !ev[2])      m_cur = (m_cur + 1) % 3;
            else if (ev[2] && !ev[3]) m_cur = (m_cur + 2) % 3;
            m_inc = ev[1] && !ev[0];
            m_dec = ev[0] && !ev[1];
            if (ev[3:0] != 4'b0) begin
                m_age = 0;
            end else if (m_age == TMO - 1) begin
                m_mode = 0;
                m_cur  = 0;
                m_age  = 0;
            end else begin
                m_age++;
            end
        end
    endtask

    function automatic logic [6:0] expected();
        logic parp;
        parp = (m_mode != 0) && (((m_age / BLINK) % 2) == 0);
        return {2'(m_mode), 2'(m_cur), parp, m_inc, m_dec};
    endfunction

    task automatic cyc(input logic [4:0] b, input logic r);
        @(negedge clk);
        {bus.btn_modo, bus.btn_izq, bus.btn_der, bus.btn_arriba, bus.btn_abajo} = b;
        reset = r;
        if (r) begin
            m_mode = 0; m_cur = 0; m_age = 0; m_inc = 1'b0; m_dec = 1'b0;
            m_prev = 5'b11111;
            m_pend = 5'b00000;
        end else begin
            model_apply(m_pend);
            m_pend = b & ~m_prev;
            m_prev = b;
        end
        exp_q.push_back(expected());
    endtask

    task automatic press(input logic [4:0] b);
        cyc(b, 1'b0);
        cyc(B_NONE, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(B_NONE, 1'b0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic [6:0] e;
                logic [6:0] got;
                e   = exp_q.pop_front();
                got = {bus.config_mode, bus.cursor_location, bus.parpadeo, bus.inc, bus.dec};
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL outputs vec=%0d t=%0t {mode,cur,parp,inc,dec} got=%b_%b_%b_%b_%b want=%b_%b_%b_%b_%b",
                             vectors, $time, got[6:5], got[4:3], got[2], got[1], got[0],
                             e[6:5], e[4:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        {bus.btn_modo, bus.btn_izq, bus.btn_der, bus.btn_arriba, bus.btn_abajo} = B_NONE;
        m_prev = 5'b11111;
        m_pend = 5'b00000;
        m_mode = 0; m_cur = 0; m_age = 0; m_inc = 1'b0; m_dec = 1'b0;

        // modo held through reset, then released and pressed once
        repeat (3) cyc(B_MODO, 1'b1);
        repeat (3) cyc(B_MODO, 1'b0);
        idle(2);
        press(B_MODO);
        press(B_MODO);
        press(B_MODO);
        press(B_MODO);

        // cursor walk in HORA
        cyc(B_NONE, 1'b1);
        idle(1);
        press(B_MODO);
        repeat (3) press(B_IZQ);
        repeat (3) press(B_DER);
        press(B_IZQ | B_DER);

        // FECHA: held arriba, arriba+abajo, modo+arriba
        press(B_MODO);
        repeat (10) cyc(B_ARR, 1'b0);
        idle(2);
        press(B_ARR | B_ABA);
        press(B_ABA);
        press(B_MODO | B_ARR);

        // TIMER idle: blink then timeout
        idle(TMO + 6);

        // back to TIMER, der around the timeout boundary
        press(B_MODO); press(B_MODO); press(B_MODO);
        idle(TMO - 4);
        press(B_DER);
        idle(TMO - 3);
        press(B_DER);
        idle(TMO + 2);

        // reset while an inc pulse is out
        press(B_MODO);
        cyc(B_ARR, 1'b0);
        cyc(B_NONE, 1'b0);
        cyc(B_NONE, 1'b1);
        idle(3);

        for (int i = 0; i < 1500; i++) begin
            int unsigned r;
            int unsigned n;
            logic [4:0]  b;
            r = $urandom_range(0, 99);
            n = $urandom_range(1, 3);
            if (r < 45)      b = B_NONE;
            else if (r < 80) b = 5'(1) << $urandom_range(0, 3);
            else if (r < 88) b = B_MODO;
            else             b = 5'($urandom);
            if (r == 99) begin
                cyc(b, 1'b1);
            end else begin
                for (int k = 0; k < int'(n); k++) cyc(b, 1'b0);
            end
            if ($urandom_range(0, 39) == 0) idle($urandom_range(14, 24));
        end

        idle(2);
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
